// File: rtl/hazard_pkg.sv
// Shared types and latency helpers for the hazard scoreboard.
// Field widths here fix the REG_AW/LAT_W the scoreboard is built with.
package hazard_pkg;

  localparam int unsigned HZ_REG_AW = 5;
  localparam int unsigned HZ_LAT_W  = 3;

  typedef struct packed {
    logic                  valid;
    logic [HZ_REG_AW-1:0]  rd;
    logic [HZ_LAT_W-1:0]   ready_cnt;
    logic [HZ_LAT_W:0]     retire_cnt;
    logic                  superseded;
  } sb_entry_t;

  // A latency of zero behaves as a single-cycle writer.
  function automatic logic [HZ_LAT_W-1:0] clamp_lat(input logic [HZ_LAT_W-1:0] lat);
    return (lat == '0) ? HZ_LAT_W'(1) : lat;
  endfunction

  // Cycles from allocation until the register file holds the result, minus one.
  function automatic logic [HZ_LAT_W:0] retire_lat(input logic [HZ_LAT_W-1:0] lat,
                                                   input int unsigned       wb_extra);
    logic [31:0] sum;
    sum = 32'(clamp_lat(lat)) + wb_extra - 32'd1;
    return (HZ_LAT_W+1)'(sum);
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: countdown counters, source compares and WAW checks.
// HAZARD_FORWARD_EN keeps the ready counter; otherwise RAW holds until retire.
module hazard_sb_entry
  import hazard_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc,
  input  logic                 alloc_fire,
  input  sb_entry_t            alloc_entry,
  input  logic [HZ_REG_AW-1:0] rs1,
  input  logic [HZ_REG_AW-1:0] rs2,
  input  logic                 use_rs1,
  input  logic                 use_rs2,
  output logic                 busy,
  output logic                 raw_rs1_c,
  output logic                 raw_rs2_c,
  output logic                 fwd_rs1_c,
  output logic                 fwd_rs2_c,
  output logic                 waw_block_c
);

  sb_entry_t             entry;
  logic                  live;
  logic                  match_rs1;
  logic                  match_rs2;
  logic                  waw_hit;
  logic [HZ_LAT_W-1:0]   ready_nxt;
  logic [HZ_LAT_W:0]     retire_nxt;

  assign live      = entry.valid & ~entry.superseded;
  assign match_rs1 = use_rs1 & (rs1 != '0) & live & (entry.rd == rs1);
  assign match_rs2 = use_rs2 & (rs2 != '0) & live & (entry.rd == rs2);

`ifdef HAZARD_FORWARD_EN
  assign raw_rs1_c = match_rs1 & (entry.ready_cnt != '0);
  assign raw_rs2_c = match_rs2 & (entry.ready_cnt != '0);
  assign fwd_rs1_c = match_rs1 & (entry.ready_cnt == '0);
  assign fwd_rs2_c = match_rs2 & (entry.ready_cnt == '0);
  assign ready_nxt = (entry.ready_cnt != '0) ? entry.ready_cnt - HZ_LAT_W'(1) : '0;
`else
  // Without bypass the value only exists once it reaches the register file.
  logic unused_ready;
  assign unused_ready = ^entry.ready_cnt;
  assign raw_rs1_c    = match_rs1;
  assign raw_rs2_c    = match_rs2;
  assign fwd_rs1_c    = 1'b0;
  assign fwd_rs2_c    = 1'b0;
  assign ready_nxt    = '0;
`endif

  assign retire_nxt  = (entry.retire_cnt != '0) ? entry.retire_cnt - (HZ_LAT_W+1)'(1) : '0;
  assign waw_hit     = live & (entry.rd == alloc_entry.rd);
  assign waw_block_c = waw_hit & (entry.retire_cnt > alloc_entry.retire_cnt);
  assign busy        = entry.valid;

  // Countdown, free on retire, and hand ownership of rd to a younger writer.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry <= '0;
    end else if (alloc) begin
      entry <= alloc_entry;
    end else if (entry.valid) begin
      entry.ready_cnt  <= ready_nxt;
      entry.retire_cnt <= retire_nxt;
      if (retire_nxt == '0) entry.valid <= 1'b0;
      if (alloc_fire && waw_hit) entry.superseded <= 1'b1;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based hazard controller: priority allocator, flush counter, output reduction.
// Define HAZARD_FORWARD_EN to enable bypass (fwd_rs1/fwd_rs2 and early RAW release).
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW       = HZ_REG_AW,
  parameter int unsigned SB_DEPTH     = 4,
  parameter int unsigned LAT_W        = HZ_LAT_W,
  parameter int unsigned WB_EXTRA     = 2,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_writes,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [LAT_W-1:0]  id_lat,
  input  logic              redirect,
  output logic              stall,
  output logic              flush,
  output logic              fwd_rs1,
  output logic              fwd_rs2,
  output logic              sb_full
);

  localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [FC_W-1:0]     flush_cnt;
  logic [SB_DEPTH-1:0] busy;
  logic [SB_DEPTH-1:0] raw_rs1;
  logic [SB_DEPTH-1:0] raw_rs2;
  logic [SB_DEPTH-1:0] hit_rs1;
  logic [SB_DEPTH-1:0] hit_rs2;
  logic [SB_DEPTH-1:0] waw_block;
  logic [SB_DEPTH-1:0] alloc_sel;
  logic                alloc_req;
  logic                alloc_fire;
  sb_entry_t           alloc_entry;

  // Payload written into the selected entry; counters already reflect one elapsed cycle.
  always_comb begin
    alloc_entry            = '0;
    alloc_entry.valid      = 1'b1;
    alloc_entry.rd         = HZ_REG_AW'(id_rd);
`ifdef HAZARD_FORWARD_EN
    alloc_entry.ready_cnt  = clamp_lat(HZ_LAT_W'(id_lat)) - HZ_LAT_W'(1);
`endif
    alloc_entry.retire_cnt = retire_lat(HZ_LAT_W'(id_lat), WB_EXTRA);
  end

  assign alloc_req  = id_valid & id_writes & (id_rd != '0);
  assign sb_full    = &busy;
  assign flush      = redirect | (flush_cnt != '0);
  assign stall      = id_valid & ~flush &
                      ((|raw_rs1) | (|raw_rs2) | (alloc_req & ((|waw_block) | sb_full)));
  assign alloc_fire = alloc_req & ~stall & ~flush;
  assign fwd_rs1    = |hit_rs1;
  assign fwd_rs2    = |hit_rs2;

  // Lowest-index free entry wins; busy is pre-update so a same-cycle free is not reused.
  always_comb begin
    logic found;
    alloc_sel = '0;
    found     = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (!busy[i] && !found) begin
        alloc_sel[i] = alloc_fire;
        found        = 1'b1;
      end
    end
  end

  // A redirect (re)starts the hold so back-to-back redirects extend the flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= '0;
    end else if (redirect) begin
      flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
    end else if (flush_cnt != '0) begin
      flush_cnt <= flush_cnt - FC_W'(1);
    end
  end

  for (genvar i = 0; i < SB_DEPTH; i++) begin : g_entry
    hazard_sb_entry u_entry (
      .clk         (clk),
      .rst         (rst),
      .alloc       (alloc_sel[i]),
      .alloc_fire  (alloc_fire),
      .alloc_entry (alloc_entry),
      .rs1         (HZ_REG_AW'(id_rs1)),
      .rs2         (HZ_REG_AW'(id_rs2)),
      .use_rs1     (id_use_rs1),
      .use_rs2     (id_use_rs2),
      .busy        (busy[i]),
      .raw_rs1_c   (raw_rs1[i]),
      .raw_rs2_c   (raw_rs2[i]),
      .fwd_rs1_c   (hit_rs1[i]),
      .fwd_rs2_c   (hit_rs2[i]),
      .waw_block_c (waw_block[i])
    );
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; expectations follow HAZARD_FORWARD_EN if defined.
module tb_hazard_scoreboard;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs1, id_use_rs2, id_writes, redirect;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [2:0] id_lat;
  logic       stall, flush, fwd_rs1, fwd_rs2, sb_full;

  int vectors     = 0;
  int miscompares = 0;

  hazard_scoreboard #(
    .REG_AW(5), .SB_DEPTH(4), .LAT_W(3), .WB_EXTRA(2), .FLUSH_CYCLES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .id_writes  (id_writes),
    .id_rd      (id_rd),
    .id_lat     (id_lat),
    .redirect   (redirect),
    .stall      (stall),
    .flush      (flush),
    .fwd_rs1    (fwd_rs1),
    .fwd_rs2    (fwd_rs2),
    .sb_full    (sb_full)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic set_id(input logic v, input logic w, input int rd, input int lat,
                        input int r1, input logic u1, input int r2, input logic u2);
    id_valid   = v;
    id_writes  = w;
    id_rd      = 5'(rd);
    id_lat     = 3'(lat);
    id_rs1     = 5'(r1);
    id_use_rs1 = u1;
    id_rs2     = 5'(r2);
    id_use_rs2 = u2;
  endtask

  task automatic idle();
    set_id(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0);
    redirect = 1'b0;
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    sample();
    chk("rst_stall", stall, 1'b0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_full", sb_full, 1'b0);
    chk("rst_fwd1", fwd_rs1, 1'b0);
    chk("rst_fwd2", fwd_rs2, 1'b0);
    rst = 1'b0;
    step();

    // L=2 writer of x5, then dependants on rs1 and rs2
    set_id(1'b1, 1'b1, 5, 2, 0, 1'b0, 0, 1'b0);
    sample(); chk("l2_alloc_stall", stall, 1'b0); step();
    set_id(1'b1, 1'b0, 0, 0, 5, 1'b1, 0, 1'b0);
    sample(); chk("l2_t1_stall", stall, 1'b1); chk("l2_t1_fwd1", fwd_rs1, 1'b0); step();
    sample(); chk("l2_t2_stall", stall, !FWD); chk("l2_t2_fwd1", fwd_rs1, FWD); step();
    set_id(1'b1, 1'b0, 0, 0, 0, 1'b0, 5, 1'b1);
    sample(); chk("l2_t3_stall", stall, !FWD); chk("l2_t3_fwd2", fwd_rs2, FWD); step();
    sample(); chk("l2_t4_stall", stall, 1'b0); chk("l2_t4_fwd2", fwd_rs2, 1'b0); step();

    // x0 is never tracked
    set_id(1'b1, 1'b1, 0, 3, 0, 1'b0, 0, 1'b0);
    sample(); chk("x0_write_stall", stall, 1'b0); step();
    set_id(1'b1, 1'b0, 0, 0, 0, 1'b1, 0, 1'b1);
    sample();
    chk("x0_read_stall", stall, 1'b0);
    chk("x0_read_fwd1", fwd_rs1, 1'b0);
    chk("x0_read_fwd2", fwd_rs2, 1'b0);
    step();

    // id_lat = 0 behaves as L=1
    set_id(1'b1, 1'b1, 8, 0, 0, 1'b0, 0, 1'b0);
    step();
    set_id(1'b1, 1'b0, 0, 0, 8, 1'b1, 0, 1'b0);
    sample(); chk("lat0_stall", stall, !FWD); chk("lat0_fwd1", fwd_rs1, FWD); step();
    idle(); step(); step();

    // Fill all entries with L=7 writers, fifth writer waits for the first to free
    for (int i = 1; i <= 4; i++) begin
      set_id(1'b1, 1'b1, i, 7, 0, 1'b0, 0, 1'b0);
      sample(); chk("fill_stall", stall, 1'b0); step();
    end
    set_id(1'b1, 1'b1, 7, 1, 0, 1'b0, 0, 1'b0);
    for (int k = 4; k <= 8; k++) begin
      sample(); chk("full_stall", stall, 1'b1); chk("full_flag", sb_full, 1'b1); step();
    end
    sample(); chk("freed_stall", stall, 1'b0); chk("freed_full", sb_full, 1'b0); step();
    idle();
    repeat (5) step();

    // Two back-to-back redirects hold flush three cycles and block allocation
    set_id(1'b1, 1'b1, 9, 7, 0, 1'b0, 0, 1'b0);
    step();
    redirect = 1'b1;
    set_id(1'b1, 1'b1, 10, 1, 9, 1'b1, 0, 1'b0);
    sample(); chk("fl_t0_flush", flush, 1'b1); chk("fl_t0_stall", stall, 1'b0); step();
    sample(); chk("fl_t1_flush", flush, 1'b1); chk("fl_t1_stall", stall, 1'b0); step();
    redirect = 1'b0;
    sample(); chk("fl_t2_flush", flush, 1'b1); chk("fl_t2_stall", stall, 1'b0); step();
    set_id(1'b1, 1'b0, 0, 0, 10, 1'b1, 0, 1'b0);
    sample();
    chk("fl_end_flush", flush, 1'b0);
    chk("fl_noalloc_stall", stall, 1'b0);
    chk("fl_noalloc_fwd1", fwd_rs1, 1'b0);
    step();
    set_id(1'b1, 1'b0, 0, 0, 9, 1'b1, 0, 1'b0);
    sample(); chk("fl_raw_kept", stall, 1'b1); step();
    idle();
    repeat (6) step();

    // WAW: L=1 writer of x6 waits until the L=7 writer's retire_cnt <= 2
    set_id(1'b1, 1'b1, 6, 7, 0, 1'b0, 0, 1'b0);
    step();
    set_id(1'b1, 1'b1, 6, 1, 0, 1'b0, 0, 1'b0);
    sample(); chk("waw_t1_stall", stall, 1'b1); step();
    repeat (4) step();
    sample(); chk("waw_t6_stall", stall, 1'b1); step();
    sample(); chk("waw_t7_stall", stall, 1'b0); step();
    set_id(1'b1, 1'b0, 0, 0, 6, 1'b1, 0, 1'b0);
    sample(); chk("waw_read_stall", stall, !FWD); chk("waw_read_fwd1", fwd_rs1, FWD); step();
    idle();
    repeat (3) step();

    // Reset with three live entries discards them
    for (int i = 11; i <= 13; i++) begin
      set_id(1'b1, 1'b1, i, 7, 0, 1'b0, 0, 1'b0);
      step();
    end
    set_id(1'b1, 1'b0, 0, 0, 11, 1'b1, 12, 1'b1);
    sample(); chk("pre_rst_stall", stall, 1'b1); chk("pre_rst_full", sb_full, 1'b0); step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_id(1'b1, 1'b0, 0, 0, 11, 1'b1, 12, 1'b1);
    sample();
    chk("post_rst_stall", stall, 1'b0);
    chk("post_rst_full", sb_full, 1'b0);
    chk("post_rst_fwd1", fwd_rs1, 1'b0);
    chk("post_rst_fwd2", fwd_rs2, 1'b0);
    chk("post_rst_flush", flush, 1'b0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
